// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller.
package game_pkg;

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        WIN   = 2'd2,
        LOSE  = 2'd3
    } state_e;

    // Item bit positions in hit_hw and in the collected-flag vector
    localparam int unsigned HW1       = 0;
    localparam int unsigned HW2       = 1;
    localparam int unsigned HW3       = 2;
    localparam int unsigned GOLD      = 3;
    localparam int unsigned NUM_ITEMS = 4;

    localparam int unsigned SCORE_W   = 3;
    localparam int unsigned TIME_W    = 8;
    localparam int unsigned SCORE_MAX = 5;
    localparam int unsigned PTS_W     = 8;

    // Points earned by a set of newly collected items
    function automatic logic [PTS_W-1:0] item_points(input logic [NUM_ITEMS-1:0] items,
                                                     input logic [PTS_W-1:0]     gold_pts);
        return PTS_W'(items[HW1]) + PTS_W'(items[HW2]) + PTS_W'(items[HW3])
             + (items[GOLD] ? gold_pts : PTS_W'(0));
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Game-flow bus: player/frame events in, renderer control out.
interface game_sequencer_if;
    import game_pkg::*;

    logic                 btn_start;
    logic                 frame_tick;
    logic [NUM_ITEMS-1:0] hit_hw;
    logic                 player_fell;

    logic                 start;
    logic                 win;
    logic                 lose;
    logic                 dissappear_flag_1;
    logic                 dissappear_flag_2;
    logic                 dissappear_flag_3;
    logic                 dissappear_flag_4;
    logic [SCORE_W-1:0]   score;
    logic [TIME_W-1:0]    time_left;

    // Stimulus / environment side
    modport master (
        output btn_start, frame_tick, hit_hw, player_fell,
        input  start, win, lose,
        input  dissappear_flag_1, dissappear_flag_2, dissappear_flag_3, dissappear_flag_4,
        input  score, time_left
    );

    // Sequencer side
    modport slave (
        input  btn_start, frame_tick, hit_hw, player_fell,
        output start, win, lose,
        output dissappear_flag_1, dissappear_flag_2, dissappear_flag_3, dissappear_flag_4,
        output score, time_left
    );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       press_q, press_d;

    // Shift the raw level in and flag a 0->1 transition of the synced level
    always_comb begin
        sync_d  = {sync_q[0], btn_i};
        prev_d  = sync_q[1];
        press_d = sync_q[1] & ~prev_q;
    end

    // Synchronizer, history and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/game_sequencer.sv
// Title/play/win/lose sequencer driving the frame renderer.
// Define GAME_SEQ_TIMER_EN to build the per-second deadline countdown.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned FPS         = 60,
    parameter int unsigned TIME_LIMIT  = 90,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned GOLD_POINTS = 2
) (
    input logic             clk,
    input logic             rst_n,
    game_sequencer_if.slave bus
);

    localparam int unsigned HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

    state_e               state_q, state_d;
    logic [NUM_ITEMS-1:0] flags_q, flags_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [TIME_W-1:0]    time_left_q, time_left_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 start_q, start_d;
    logic                 win_q, win_d;
    logic                 lose_q, lose_d;

    logic                 press;
    logic                 sec_tick;
    logic                 timeout;
    logic                 all_hw;
    logic [NUM_ITEMS-1:0] new_items;
    logic [PTS_W-1:0]     sum;

    btn_sync_edge u_btn_start (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.btn_start),
        .press_o (press)
    );

`ifdef GAME_SEQ_TIMER_EN
    localparam int unsigned DIV_W = (FPS < 2) ? 1 : $clog2(FPS);

    logic [DIV_W-1:0] div_q, div_d;

    // Frame divider: restarts with each game, wraps once per second of play
    always_comb begin
        div_d    = div_q;
        sec_tick = 1'b0;
        if (state_q == TITLE && press) begin
            div_d = '0;
        end else if (state_q == PLAY && bus.frame_tick) begin
            if (div_q == DIV_W'(FPS - 1)) begin
                div_d    = '0;
                sec_tick = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Divider register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    logic unused_fps;

    assign sec_tick   = 1'b0;
    assign unused_fps = ^32'(FPS);
`endif

    // Game flow: once-per-frame decisions in PLAY, hold-off in WIN/LOSE
    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        score_d     = score_q;
        time_left_d = time_left_q;
        hold_d      = hold_q;
        timeout     = 1'b0;
        new_items   = bus.hit_hw & ~flags_q;
        sum         = PTS_W'(score_q) + item_points(new_items, PTS_W'(GOLD_POINTS));
        all_hw      = 1'b0;

        case (state_q)
            TITLE: begin
                if (press) begin
                    state_d     = PLAY;
                    flags_d     = '0;
                    score_d     = '0;
                    time_left_d = TIME_W'(TIME_LIMIT);
                end
            end
            PLAY: begin
                if (bus.frame_tick) begin
                    flags_d = flags_q | bus.hit_hw;
                    score_d = (sum > PTS_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : SCORE_W'(sum);
                    if (sec_tick && time_left_q != '0) begin
                        time_left_d = time_left_q - TIME_W'(1);
                        timeout     = (time_left_q == TIME_W'(1));
                    end
                    all_hw = flags_d[HW1] & flags_d[HW2] & flags_d[HW3];
                    if (all_hw) begin
                        state_d = WIN;
                        hold_d  = '0;
                    end else if (bus.player_fell || timeout) begin
                        state_d = LOSE;
                        hold_d  = '0;
                    end
                end
            end
            WIN, LOSE: begin
                if (bus.frame_tick && hold_q < HOLD_W'(HOLD_FRAMES)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (press && hold_q >= HOLD_W'(HOLD_FRAMES)) begin
                    state_d = TITLE;
                end
            end
            default: state_d = TITLE;
        endcase

        start_d = (state_d != TITLE);
        win_d   = (state_d == WIN);
        lose_d  = (state_d == LOSE);
    end

    // State, game data and registered renderer controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TITLE;
            flags_q     <= '0;
            score_q     <= '0;
            time_left_q <= TIME_W'(TIME_LIMIT);
            hold_q      <= '0;
            start_q     <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            score_q     <= score_d;
            time_left_q <= time_left_d;
            hold_q      <= hold_d;
            start_q     <= start_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
        end
    end

    assign bus.start             = start_q;
    assign bus.win               = win_q;
    assign bus.lose              = lose_q;
    assign bus.dissappear_flag_1 = flags_q[HW1];
    assign bus.dissappear_flag_2 = flags_q[HW2];
    assign bus.dissappear_flag_3 = flags_q[HW3];
    assign bus.dissappear_flag_4 = flags_q[GOLD];
    assign bus.score             = score_q;
    assign bus.time_left         = time_left_q;

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller that sequences the frame renderer. Owns the title/play/win/lose state machine, latches homework pickups into the per-item disappear flags, keeps score and the deadline countdown, and drives the `start`, `win`, `lose` and `dissappear_flag_1..4` inputs of the draw controller. All decisions are taken once per frame on `frame_tick`, so the picture never changes mid-frame.

## Interface
Parameters:
- `FPS`, 60: frame ticks per second of countdown.
- `TIME_LIMIT`, 90: deadline length in seconds, 1..255.
- `HOLD_FRAMES`, 30: frames after entering WIN/LOSE during which the start button is ignored.
- `GOLD_POINTS`, 2: score value of the gold item; regular homework scores 1.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`, in, 1: pixel-domain clock, also used by the sprite displays.
- `rst_n`, in, 1: asynchronous active-low reset.
- `btn_start`, in, 1: raw start button, asynchronous level.
- `frame_tick`, in, 1: one-cycle pulse per frame at vertical blank.
- `hit_hw`, in, 4: player-sprite overlap per item. Bits [0..2] are hw1..hw3 and bit [3] is gold. Valid on `frame_tick`.
- `player_fell`, in, 1: player has left the bottom of the playfield. Valid on `frame_tick`.
- `start`, out, 1: game started. High in PLAY, WIN and LOSE.
- `win`, out, 1: high in WIN.
- `lose`, out, 1: high in LOSE.
- `dissappear_flag_1` .. `dissappear_flag_4`, out, 1 each: item collected. Flag 4 is gold.
- `score`, out, 3: points collected, 0..5.
- `time_left`, out, 8: seconds remaining.

## Operation
- States: TITLE, PLAY, WIN, LOSE. Reset enters TITLE.
- `btn_start` passes through a 2-flop synchronizer and a rising-edge detector, giving `press`.
- TITLE → PLAY on `press`. On this transition:
  - clear all flags and `score`;
  - load `time_left` = TIME_LIMIT;
  - clear the frame divider.
- PLAY, evaluated only on cycles where `frame_tick`=1:
  - Newly collected items are `hit_hw & ~flags`. Set each of these flags.
  - Add 1 to `score` per new hw bit and GOLD_POINTS for a new gold bit. Saturate at 5.
  - Win condition: flags 1..3 all set after this update. Gold is optional.
  - Lose condition: `player_fell`, or timeout (see Configuration).
  - If win and lose are both true on the same tick, WIN takes priority.
  - Collection and win are evaluated on the same tick, so the last pickup wins immediately.
- WIN and LOSE:
  - flags, `score` and `time_left` are frozen;
  - a hold counter counts HOLD_FRAMES frame ticks;
  - after the hold, `press` → TITLE;
  - a `press` during the hold is discarded, not queued.
- `hit_hw` and `player_fell` are ignored outside PLAY.
- `press` in PLAY is ignored. There is no pause.

## Timing
- Reset values:
  - state TITLE;
  - `start`=`win`=`lose`=0;
  - all flags 0;
  - `score`=0;
  - `time_left`=TIME_LIMIT;
  - divider and hold counter 0.
- All outputs are registered and decoded directly from state or flops. There are no combinational paths from input to output.
- Latency from a `btn_start` edge to `start`: 4 clk, made up of 2 sync flops, 1 edge flop and 1 state flop.
- A PLAY decision sampled on the `frame_tick` cycle appears at the outputs 1 clk later, always before active video.
- Reset mid-game returns immediately to TITLE with reset values. No partial state survives.
- `frame_tick` held high for more than 1 cycle is out of contract.

## Configuration
- `GAME_SEQ_TIMER_EN` defined:
  - the frame divider counts 0..FPS-1;
  - on wrap in PLAY, `time_left` decrements;
  - when the decrement reaches 0, this is a timeout and the state goes to LOSE on that tick;
  - `time_left` never underflows.
- `GAME_SEQ_TIMER_EN` undefined:
  - no divider is built;
  - `time_left` stays constant at TIME_LIMIT;
  - loss occurs only on `player_fell`.

## Structure
- Shared package `game_pkg` holds:
  - the state enum (TITLE, PLAY, WIN, LOSE, 2 bits);
  - item index constants (HW1=0, HW2=1, HW3=2, GOLD=3);
  - `SCORE_MAX`=5 and the score and time widths.
- Sub-module `btn_sync_edge` (synchronizer plus rising-edge pulse). It is reused for future buttons.

## Test plan
- Reset, then `btn_start` 0→1 → `start`=1 exactly 4 clk after the edge, `time_left`=90, `score`=0, flags 0.
- In PLAY, `hit_hw`=4'b1000 on a tick, then 4'b1000 again → `dissappear_flag_4`=1 and `score`=2, with no double count.
- `hit_hw`=4'b0011 on a tick, then 4'b0100 with `player_fell`=1 on the same tick → WIN, `win`=1, `lose`=0, `score`=3.
- Timer enabled with TIME_LIMIT=2, FPS=4 and no hits → `time_left` 2→1→0 at ticks 4 and 8, `lose`=1 after tick 8. With the macro off, still PLAY after 100 ticks.
- In LOSE, press at frame 10 → ignored. Press after 30 frames → TITLE, `start`=0, flags still frozen until the next press clears them.
- `rst_n` pulled low mid-PLAY with `score`=3 → all outputs return to reset values asynchronously.
